irq_ctrl_wb: RTL and testbench

- Wishbone B-4 slave interrupt controller that sits directly downstream of the timer and other peripherals.
- Collects up to NSRC interrupt lines (the timer's int_o is source 0) and latches them as pending.
- Masks the pending set with an enable register and drives a single level irq_o to the core.
- Provides claim/complete registers so software can identify and retire the active source.
- Source priority is fixed: the lowest index wins.

---
 rtl/irq_ctrl_wb.sv | 151 +++++++++++++++
 tb/tb_irq_ctrl_wb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_wb.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_wb
// Description : Wishbone B-4 slave interrupt controller with level/edge
//               sources, enable mask, fixed priority and claim/complete.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl_wb #(
    parameter int NSRC = 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [4:2]      wb_adr_i,
    output logic [31:0]     wb_dat_o,
    input  logic [31:0]     wb_dat_i,
    input  logic            wb_we_i,
    input  logic [3:0]      wb_sel_i,
    input  logic            wb_stb_i,
    output logic            wb_ack_o,
    input  logic [NSRC-1:0] irq_i,
    output logic            irq_o
);

    localparam logic [2:0] c_ADR_PENDING  = 3'd0;
    localparam logic [2:0] c_ADR_ENABLE   = 3'd1;
    localparam logic [2:0] c_ADR_TYPE     = 3'd2;
    localparam logic [2:0] c_ADR_CLAIM    = 3'd3;
    localparam logic [2:0] c_ADR_COMPLETE = 3'd4;

    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_enable;
    logic [NSRC-1:0] r_type;
    logic [NSRC-1:0] r_inservice;
    logic [NSRC-1:0] r_irq_prev;
    logic            r_ack;
    logic [31:0]     r_dat;
    logic            r_irq;

    logic            w_access;
    logic            w_rd;
    logic            w_wr;
    logic            w_w1c;
    logic            w_claim;
    logic            w_complete;
    logic [NSRC-1:0] w_lane;
    logic [NSRC-1:0] w_wdata;
    logic [NSRC-1:0] w_eligible;
    logic [NSRC-1:0] w_claim_onehot;
    logic [5:0]      w_claim_id;
    logic [NSRC-1:0] w_claim_set;
    logic [NSRC-1:0] w_cpl_clr;
    logic [NSRC-1:0] w_pend_nxt;
    logic [31:0]     w_rdata;
    logic            w_unused_bits;

    // Only the first cycle of a strobe is processed; the ack cycle is idle.
    assign w_access   = wb_stb_i & ~r_ack;
    assign w_rd       = w_access & ~wb_we_i;
    assign w_wr       = w_access &  wb_we_i;
    assign w_w1c      = w_wr & (wb_adr_i == c_ADR_PENDING);
    assign w_complete = w_wr & (wb_adr_i == c_ADR_COMPLETE) & wb_sel_i[0];
    assign w_claim    = w_rd & (wb_adr_i == c_ADR_CLAIM) & (|w_eligible);

    assign w_eligible  = r_pending & r_enable & ~r_inservice;
    assign w_wdata     = wb_dat_i[NSRC-1:0];
    assign w_claim_set = w_claim ? w_claim_onehot : '0;

    assign w_unused_bits = &{1'b0, wb_dat_i, wb_sel_i};

    generate
        for (genvar n = 0; n < NSRC; n++) begin : g_src
            logic w_rise;
            logic w_clr;

            assign w_lane[n] = wb_sel_i[n / 8];
            assign w_rise    = irq_i[n] & ~r_irq_prev[n];
            assign w_clr     = (w_w1c & w_lane[n] & wb_dat_i[n]) | w_claim_set[n];
            // Edge sources: a fresh edge beats any clear in the same cycle.
            assign w_pend_nxt[n] = r_type[n] ? (w_rise | (r_pending[n] & ~w_clr))
                                             : irq_i[n];
        end
    endgenerate

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        w_claim_onehot = '0;
        w_claim_id     = 6'd0;
        for (int n = NSRC - 1; n >= 0; n--) begin
            if (w_eligible[n]) begin
                w_claim_onehot    = '0;
                w_claim_onehot[n] = 1'b1;
                w_claim_id        = 6'(n + 1);
            end
        end
    end

    always_comb begin
        w_cpl_clr = '0;
        for (int n = 0; n < NSRC; n++) begin
            if (w_complete && (wb_dat_i[5:0] == 6'(n + 1))) begin
                w_cpl_clr[n] = 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (wb_adr_i)
            c_ADR_PENDING: w_rdata[NSRC-1:0] = r_pending;
            c_ADR_ENABLE:  w_rdata[NSRC-1:0] = r_enable;
            c_ADR_TYPE:    w_rdata[NSRC-1:0] = r_type;
            c_ADR_CLAIM:   w_rdata[5:0]      = w_claim_id;
            default:       w_rdata           = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack       <= 1'b0;
            r_dat       <= 32'd0;
            r_irq       <= 1'b0;
            r_pending   <= '0;
            r_enable    <= '0;
            r_type      <= '0;
            r_inservice <= '0;
            r_irq_prev  <= '0;
        end else begin
            r_ack      <= wb_stb_i & ~r_ack;
            r_irq      <= |w_eligible;
            r_irq_prev <= irq_i;
            r_pending  <= w_pend_nxt;
            // Claim and complete are never in the same cycle.
            r_inservice <= (r_inservice | w_claim_set) & ~w_cpl_clr;
            if (w_access) begin
                r_dat <= w_rdata;
            end
            if (w_wr && (wb_adr_i == c_ADR_ENABLE)) begin
                r_enable <= (r_enable & ~w_lane) | (w_wdata & w_lane);
            end
            if (w_wr && (wb_adr_i == c_ADR_TYPE)) begin
                r_type <= (r_type & ~w_lane) | (w_wdata & w_lane);
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign irq_o    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl_wb
// Description : Directed and randomized bench for irq_ctrl_wb with a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl_wb;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   adr;
    logic [31:0]  wdat;
    logic         we;
    logic [3:0]   sel;
    logic         stb;
    logic [N-1:0] irq;
    logic [31:0]  wb_dat_o;
    logic         wb_ack_o;
    logic         irq_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_pend, m_en, m_type, m_insv, m_prev;
    logic         m_irq, m_ack;
    logic [31:0]  m_dat;

    irq_ctrl_wb #(.NSRC(N)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wdat),
        .wb_we_i  (we),
        .wb_sel_i (sel),
        .wb_stb_i (stb),
        .wb_ack_o (wb_ack_o),
        .irq_i    (irq),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge of the behavioural model, from the inputs seen at that edge.
    task automatic model_update();
        logic [N-1:0] elig, np;
        logic [31:0]  rv;
        bit           acc, rise, clr;
        int           k, id;
        if (rst) begin
            m_pend = '0; m_en = '0; m_type = '0; m_insv = '0; m_prev = '0;
            m_irq = 1'b0; m_ack = 1'b0; m_dat = 32'd0;
            return;
        end
        elig = m_pend & m_en & ~m_insv;
        acc  = stb && !m_ack;
        k    = -1;
        for (int i = 0; i < N; i++) if (elig[i] && k < 0) k = i;
        for (int i = 0; i < N; i++) begin
            if (!m_type[i]) np[i] = irq[i];
            else begin
                rise = irq[i] && !m_prev[i];
                clr  = (acc && we && adr == 0 && wdat[i] && sel[i/8]) ||
                       (acc && !we && adr == 3 && k == i);
                np[i] = rise ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
            end
        end
        case (adr)
            3'd0:    rv = 32'(m_pend);
            3'd1:    rv = 32'(m_en);
            3'd2:    rv = 32'(m_type);
            3'd3:    rv = (k >= 0) ? 32'(k + 1) : 32'd0;
            default: rv = 32'd0;
        endcase
        if (acc) begin
            m_dat = rv;
            if (!we && adr == 3 && k >= 0) m_insv[k] = 1'b1;
            if (we) begin
                for (int i = 0; i < N; i++) begin
                    if (sel[i/8] && adr == 1) m_en[i] = wdat[i];
                    if (sel[i/8] && adr == 2) m_type[i] = wdat[i];
                end
                id = int'(wdat[5:0]);
                if (adr == 4 && sel[0] && id >= 1 && id <= N) m_insv[id-1] = 1'b0;
            end
        end
        m_irq  = |elig;
        m_ack  = stb && !m_ack;
        m_prev = irq;
        m_pend = np;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("ack_model", {31'd0, wb_ack_o}, {31'd0, m_ack});
        chk("dat_model", wb_dat_o, m_dat);
        chk("irq_model", {31'd0, irq_o}, {31'd0, m_irq});
    endtask

    task automatic wb_xfer(input logic [2:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
        int n;
        adr = a; we = w; wdat = d; sel = s; stb = 1'b1;
        step();
        n = 0;
        while (wb_ack_o !== 1'b1 && n < 4) begin
            step();
            n++;
        end
        chk("ack_seen", {31'd0, wb_ack_o}, 32'd1);
        q = wb_dat_o;
        stb = 1'b0; we = 1'b0;
        step();
        chk("ack_width", {31'd0, wb_ack_o}, 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        wb_xfer(a, 1'b1, d, s, q);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] q);
        wb_xfer(a, 1'b0, 32'd0, 4'hF, q);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq = irq | m;
        step();
        irq = irq & ~m;
        step();
    endtask

    initial begin
        logic [31:0] q;
        rst = 1'b1; adr = '0; wdat = '0; we = 1'b0; sel = '0; stb = 1'b0; irq = '0;
        m_pend = '0; m_en = '0; m_type = '0; m_insv = '0; m_prev = '0;
        m_irq = 1'b0; m_ack = 1'b0; m_dat = '0;

        // Reset
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        rd(3'd1, q); chk("rst_enable", q, 32'd0);
        rd(3'd0, q); chk("rst_pending", q, 32'd0);
        rd(3'd3, q); chk("rst_claim", q, 32'd0);

        // Level source 0
        wr(3'd1, 32'h1, 4'hF);
        wr(3'd2, 32'h0, 4'hF);
        irq[0] = 1'b1;
        step(); step();
        chk("lvl_irq_on", {31'd0, irq_o}, 32'd1);
        rd(3'd3, q); chk("lvl_claim", q, 32'h1);
        chk("lvl_irq_masked", {31'd0, irq_o}, 32'd0);
        wr(3'd4, 32'h1, 4'h1);
        chk("lvl_irq_reassert", {31'd0, irq_o}, 32'd1);
        irq[0] = 1'b0;
        step();
        rd(3'd0, q); chk("lvl_pend_drop", q, 32'h0);

        // Edge source 2
        wr(3'd2, 32'h4, 4'hF);
        wr(3'd1, 32'h4, 4'hF);
        pulse(8'h04);
        rd(3'd0, q); chk("edge_pend", q, 32'h4);
        rd(3'd0, q); chk("edge_pend_hold", q, 32'h4);
        chk("edge_irq", {31'd0, irq_o}, 32'd1);
        wr(3'd0, 32'h4, 4'h1);
        chk("edge_w1c_irq", {31'd0, irq_o}, 32'd0);
        rd(3'd0, q); chk("edge_w1c_pend", q, 32'h0);
        pulse(8'h04);
        rd(3'd3, q); chk("edge_claim", q, 32'h3);
        rd(3'd0, q); chk("edge_claim_pend", q, 32'h0);
        wr(3'd4, 32'h3, 4'h1);

        // Priority and masking
        wr(3'd2, 32'h26, 4'hF);
        wr(3'd1, 32'hFF, 4'hF);
        pulse(8'h22);
        rd(3'd3, q); chk("prio_claim1", q, 32'h2);
        rd(3'd3, q); chk("prio_claim2", q, 32'h6);
        rd(3'd3, q); chk("prio_claim3", q, 32'h0);
        wr(3'd4, 32'h2, 4'h1);
        rd(3'd3, q); chk("prio_no_repend", q, 32'h0);
        pulse(8'h02);
        rd(3'd3, q); chk("prio_repend", q, 32'h2);
        wr(3'd4, 32'h2, 4'h1);
        wr(3'd4, 32'h6, 4'h1);

        // Byte lanes and invalid IDs
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd1, 32'hFFFF_FFFF, 4'h1);
        rd(3'd1, q); chk("lane_enable", q, 32'hFF);
        wr(3'd1, 32'h0, 4'h2);
        rd(3'd1, q); chk("lane_enable_sel2", q, 32'hFF);
        wr(3'd2, 32'h2E, 4'hF);
        pulse(8'h08);
        rd(3'd3, q); chk("inv_claim", q, 32'h4);
        pulse(8'h08);
        chk("inv_masked_irq", {31'd0, irq_o}, 32'd0);
        wr(3'd4, 32'h0, 4'h1);
        wr(3'd4, 32'h9, 4'h1);
        wr(3'd4, 32'h3F, 4'h1);
        wr(3'd4, 32'h4, 4'h2);
        chk("inv_irq_still_off", {31'd0, irq_o}, 32'd0);
        rd(3'd3, q); chk("inv_claim_none", q, 32'h0);
        rd(3'd0, q); chk("inv_pend", q, 32'h08);
        wr(3'd4, 32'h4, 4'h1);
        chk("inv_cpl_irq", {31'd0, irq_o}, 32'd1);
        rd(3'd3, q); chk("inv_reclaim", q, 32'h4);
        wr(3'd4, 32'h4, 4'h1);

        // New edge in the same cycle as the claim
        pulse(8'h08);
        irq[3] = 1'b1;
        rd(3'd3, q); chk("sim_claim", q, 32'h4);
        rd(3'd0, q); chk("sim_pend", q, 32'h08);
        chk("sim_irq_masked", {31'd0, irq_o}, 32'd0);
        irq[3] = 1'b0;
        wr(3'd4, 32'h4, 4'h1);
        chk("sim_irq_after_cpl", {31'd0, irq_o}, 32'd1);

        // Randomized phase, including resets mid-access
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            stb  = $urandom_range(0, 1) == 1;
            we   = $urandom_range(0, 1) == 1;
            adr  = 3'($urandom_range(0, 7));
            sel  = 4'($urandom);
            wdat = $urandom;
            if (adr == 3'd4) wdat = ($urandom_range(0, 3) == 0) ? 32'h3F : 32'($urandom_range(0, 10));
            irq  = irq ^ (N'($urandom) & N'($urandom) & N'($urandom));
            step();
        end
        rst = 1'b0; stb = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
